// File: rtl/cplx_pattern_pkg.sv
// cplx_pattern_pkg: shared mode encodings and FSM state type for the complex pattern generator
package cplx_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_QUAD  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/strobe_div.sv
// strobe_div: slot divider producing a one-cycle strobe at the last count and a registered divided clock
module strobe_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic strobe,
    output logic clk_out
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_out_q, clk_out_d;

    // count 0..DIV-1 while enabled, wrap on the strobe, hold otherwise
    always_comb begin
        strobe    = en && (cnt_q == CW'(DIV - 1));
        cnt_d     = (clr || strobe) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
        clk_out_d = cnt_d >= CW'(DIV / 2);
    end

    // divider state and registered divided clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

endmodule

// File: rtl/cplx_pattern_gen.sv
// cplx_pattern_gen: burst generator of complex test patterns paced by a slot divider with valid/ready output
module cplx_pattern_gen
    import cplx_pattern_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8,
    parameter int DIV      = 4,
    parameter int START_RE = 126,
    parameter int START_IM = 126,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_samples,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              clk_out,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] ST  = DATA_W'(STEP);
    localparam logic [DATA_W-1:0] SRE = DATA_W'(START_RE);
    localparam logic [DATA_W-1:0] SIM = DATA_W'(START_IM);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [DATA_W-1:0]  re_q, re_d;
    logic [DATA_W-1:0]  im_q, im_d;
    logic               strobe;
    logic               last;

    strobe_div #(.DIV(DIV)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q == RUN),
        .clr     (state_q == IDLE && start),
        .strobe  (strobe),
        .clk_out (clk_out)
    );

    // count of 0 wraps to all-ones here, giving 2^CNT_W transfers
    assign last = k_q == cnt_q - CNT_W'(1);

    // next state; the accumulators always hold the sample for the current k
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                mode_d  = mode_e'(mode);
                cnt_d   = num_samples;
                k_d     = '0;
                re_d    = SRE;
                im_d    = SIM;
            end
            RUN:  if (strobe) state_d = HOLD;
            HOLD: if (out_ready) begin
                if (last) begin
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                    k_d     = k_q + CNT_W'(1);
                    re_d    = (mode_q == MODE_RAMP || mode_q == MODE_QUAD) ? re_q + ST :
                              (mode_q == MODE_ALT) ? -re_q : re_q;
                    im_d    = (mode_q == MODE_RAMP) ? im_q + ST :
                              (mode_q == MODE_QUAD) ? im_q - ST :
                              (mode_q == MODE_ALT) ? -im_q : im_q;
                end
            end
            FIN:  state_d = IDLE;
        endcase
    end

    // state, latched burst setup and pattern accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_RAMP;
            cnt_q   <= '0;
            k_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign out_real  = re_q;
    assign out_imag  = im_q;
    assign out_valid = state_q == HOLD;
    assign busy      = state_q != IDLE;
    assign done      = state_q == FIN;

endmodule

// File: tb/tb_cplx_pattern_gen.sv
// tb_cplx_pattern_gen: directed self-checking bench for cplx_pattern_gen
module tb_cplx_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] num_samples = 8'd0;
    logic       out_ready = 1'b0;
    logic [7:0] out_real, out_imag, re2, im2;
    logic       out_valid, clk_out, busy, done, v2, co2, b2, d2;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_re [256];
    logic [7:0] got_im [256];
    logic [7:0] got2_re [256];
    logic [7:0] got2_im [256];
    int         got_cyc [256];
    int         n_got, n_done;
    bit         timed_out;

    always #5 clk = ~clk;

    cplx_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_samples(num_samples),
        .out_real(out_real), .out_imag(out_imag), .out_valid(out_valid), .out_ready(out_ready),
        .clk_out(clk_out), .busy(busy), .done(done)
    );

    cplx_pattern_gen #(.STEP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_samples(num_samples),
        .out_real(re2), .out_imag(im2), .out_valid(v2), .out_ready(out_ready),
        .clk_out(co2), .busy(b2), .done(d2)
    );

    task automatic run_burst(input logic [1:0] m, input logic [7:0] n, input int max_c);
        bit seen = 0;
        n_got = 0;
        n_done = 0;
        timed_out = 1;
        mode = m;
        num_samples = n;
        start = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) begin
                if (n_got < 256) begin
                    got_re[n_got]  = out_real;
                    got_im[n_got]  = out_imag;
                    got2_re[n_got] = re2;
                    got2_im[n_got] = im2;
                    got_cyc[n_got] = c;
                end
                n_got++;
            end
            if (done) begin
                n_done++;
                seen = 1;
            end else if (seen && !busy) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_real, out_imag} !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h exp=00/00", out_real, out_imag);
        end
        checks++;
        if ({out_valid, clk_out, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got valid/clk_out/busy/done=%b exp=0000", {out_valid, clk_out, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp;
        out_ready = 1'b1;
        run_burst(2'd0, 8'd4, 60);
        checks++;
        if (timed_out || n_got != 4) begin
            errors++;
            $display("FAIL ramp_count got=%0d timeout=%0d exp=4", n_got, timed_out);
        end
        for (int i = 0; i < 4 && i < n_got; i++) begin
            checks++;
            if (got_re[i] !== 8'(126 + i) || got_im[i] !== 8'(126 + i)) begin
                errors++;
                $display("FAIL ramp_sample%0d got=(%0d,%0d) exp=(%0d,%0d)", i, got_re[i], got_im[i], 126 + i, 126 + i);
            end
        end
        checks++;
        if (got_cyc[0] != 5) begin
            errors++;
            $display("FAIL ramp_latency got=%0d exp=5", got_cyc[0]);
        end
        for (int i = 1; i < 4 && i < n_got; i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != 5) begin
                errors++;
                $display("FAIL ramp_spacing%0d got=%0d exp=5", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        checks++;
        if (n_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_done got done_pulses=%0d busy=%b exp=1/0", n_done, busy);
        end
    endtask

    task automatic test_quad;
        out_ready = 1'b1;
        run_burst(2'd1, 8'd3, 60);
        checks++;
        if (timed_out || n_got != 3 || n_done != 1) begin
            errors++;
            $display("FAIL quad_count got=%0d done=%0d timeout=%0d exp=3/1/0", n_got, n_done, timed_out);
        end
        for (int i = 0; i < 3 && i < n_got; i++) begin
            checks++;
            if (got2_re[i] !== 8'(126 + 2 * i) || got2_im[i] !== 8'(126 - 2 * i)) begin
                errors++;
                $display("FAIL quad_step2_sample%0d got=(%0d,%0d) exp=(%0d,%0d)", i, got2_re[i], got2_im[i], 126 + 2 * i, 126 - 2 * i);
            end
            checks++;
            if (got_re[i] !== 8'(126 + i) || got_im[i] !== 8'(126 - i)) begin
                errors++;
                $display("FAIL quad_step1_sample%0d got=(%0d,%0d) exp=(%0d,%0d)", i, got_re[i], got_im[i], 126 + i, 126 - i);
            end
        end
    endtask

    task automatic test_alt;
        out_ready = 1'b1;
        run_burst(2'd3, 8'd2, 40);
        checks++;
        if (timed_out || n_got != 2 || n_done != 1) begin
            errors++;
            $display("FAIL alt_count got=%0d done=%0d timeout=%0d exp=2/1/0", n_got, n_done, timed_out);
        end
        checks++;
        if ({got_re[0], got_im[0]} !== {8'd126, 8'd126}) begin
            errors++;
            $display("FAIL alt_even got=(%h,%h) exp=(7e,7e)", got_re[0], got_im[0]);
        end
        checks++;
        if ({got_re[1], got_im[1]} !== {8'h82, 8'h82}) begin
            errors++;
            $display("FAIL alt_odd got=(%h,%h) exp=(82,82)", got_re[1], got_im[1]);
        end
    endtask

    task automatic test_stall;
        int c;
        int n = 0;
        int d = 0;
        logic [7:0] last_re = 8'd0;
        out_ready = 1'b0;
        mode = 2'd0;
        num_samples = 8'd3;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (clk_out !== (i == 3 || i == 4)) begin
                errors++;
                $display("FAIL clk_out_phase%0d got=%b exp=%b", i, clk_out, (i == 3 || i == 4));
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_real !== 8'd126) begin
            errors++;
            $display("FAIL stall_first got valid=%b re=%0d exp=1/126", out_valid, out_real);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop got=%b exp=0", out_valid);
        end
        for (c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_real !== 8'd127) begin
            errors++;
            $display("FAIL stall_second got valid=%b re=%0d exp=1/127", out_valid, out_real);
        end
        out_ready = 1'b0;
        mode = 2'd3;
        num_samples = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({out_valid, clk_out, out_real, out_imag} !== {1'b1, 1'b0, 8'd127, 8'd127}) begin
                errors++;
                $display("FAIL stall_hold%0d got valid=%b clk_out=%b data=(%0d,%0d) exp=1/0/(127,127)", i, out_valid, clk_out, out_real, out_imag);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n++;
                last_re = out_real;
            end
            if (done) d++;
            else if (d != 0 && !busy) break;
        end
        checks++;
        if (n != 1 || last_re !== 8'd128 || d != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_tail got samples=%0d re=%0d done=%0d busy=%b exp=1/128/1/0", n, last_re, d, busy);
        end
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        run_burst(2'd0, 8'd0, 1400);
        checks++;
        if (timed_out || n_got != 256 || n_done != 1) begin
            errors++;
            $display("FAIL wrap_count got=%0d done=%0d timeout=%0d exp=256/1/0", n_got, n_done, timed_out);
        end
        checks++;
        if (got_re[129] !== 8'd255 || got_re[130] !== 8'd0 || got_im[130] !== 8'd0) begin
            errors++;
            $display("FAIL wrap_point got k129=%0d k130=(%0d,%0d) exp=255/(0,0)", got_re[129], got_re[130], got_im[130]);
        end
        checks++;
        if (got_re[255] !== 8'd125) begin
            errors++;
            $display("FAIL wrap_last got=%0d exp=125", got_re[255]);
        end
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        int dones = 0;
        out_ready = 1'b1;
        mode = 2'd0;
        num_samples = 8'd4;
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_real == 8'd128) begin
                out_ready = 1'b0;
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach got=not_found exp=sample2");
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_real, out_imag, out_valid, clk_out, busy, done} !== 20'd0) begin
            errors++;
            $display("FAIL midreset_clear got data=(%0d,%0d) valid=%b clk_out=%b busy=%b done=%b exp=all0", out_real, out_imag, out_valid, clk_out, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        if (done) dones++;
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_done got=%0d exp=0", dones);
        end
        run_burst(2'd0, 8'd2, 40);
        checks++;
        if (timed_out || n_got != 2 || got_re[0] !== 8'd126 || got_re[1] !== 8'd127 || n_done != 1) begin
            errors++;
            $display("FAIL midreset_restart got n=%0d re=%0d,%0d done=%0d exp=2 126,127 1", n_got, got_re[0], got_re[1], n_done);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        run_burst(2'd2, 8'd1, 40);
        checks++;
        if (timed_out || n_got != 1 || {got_re[0], got_im[0]} !== {8'd126, 8'd126}) begin
            errors++;
            $display("FAIL b2b_first got n=%0d data=(%0d,%0d) exp=1 (126,126)", n_got, got_re[0], got_im[0]);
        end
        run_burst(2'd2, 8'd2, 40);
        checks++;
        if (timed_out || n_got != 2 || got_cyc[0] != 5) begin
            errors++;
            $display("FAIL b2b_accept got n=%0d latency=%0d exp=2/5", n_got, got_cyc[0]);
        end
        checks++;
        if ({got_re[1], got_im[1]} !== {8'd126, 8'd126}) begin
            errors++;
            $display("FAIL b2b_const got=(%0d,%0d) exp=(126,126)", got_re[1], got_im[1]);
        end
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_quad;
        test_alt;
        test_stall;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
